// File: rtl/fetch_queue_unit.sv
// Decoupled instruction-fetch front end: PC, sync-read imem driver and {pc, instr} queue.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module fetch_queue_unit #(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 12,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fetch_en,
  input  logic                      redirect,
  input  logic [PC_W-1:0]           redirect_pc,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [PC_W-1:0]           dec_pc,
  output logic [31:0]               dec_instr,
  output logic [4:0]                dec_opcode,
  output logic [$clog2(DEPTH):0]    fq_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  r_pc;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;
  logic [PC_W-1:0]  r_q_pc    [DEPTH];
  logic [31:0]      r_q_instr [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_hold_pc;
  logic [31:0]      r_hold_instr;

  logic [CNT_W:0]   w_credit;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  // Credit counts the in-flight read so the return always has a free slot.
  assign w_credit = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_issue  = fetch_en & ~redirect & (w_credit < (CNT_W+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = r_inflight & ~redirect;
  assign w_pop    = ~w_empty & dec_ready & ~redirect;

  assign imem_addr  = r_pc[ADDR_W-1:0];
  assign dec_valid  = ~w_empty;
  assign dec_pc     = w_empty ? r_hold_pc    : r_q_pc[r_rd_ptr];
  assign dec_instr  = w_empty ? r_hold_instr : r_q_instr[r_rd_ptr];
  assign dec_opcode = dec_instr[31:27];
  assign fq_count   = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + PC_W'(1);
        r_inflight_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs keep showing the last popped entry while the queue is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else if (w_pop) begin
      r_hold_pc    <= r_q_pc[r_rd_ptr];
      r_hold_instr <= r_q_instr[r_rd_ptr];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (w_pop)    perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= perf_flushed + 32'(r_count) + 32'(r_inflight);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed timing cases plus a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_queue_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [4:0]  dec_opcode;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue_unit #(.PC_W(32), .ADDR_W(12), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_opcode  (dec_opcode),
    .fq_count    (fq_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clock = ~clock;

  // Instruction image: addr+100 with the address mixed into the opcode field.
  function automatic logic [31:0] instr_of(input logic [11:0] a);
    logic [31:0] v;
    v = {20'b0, a} + 32'd100;
    return v ^ {a[4:0], 27'b0};
  endfunction

  always @(posedge clock) imem_rdata <= instr_of(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    logic [31:0] ins;
    ins = instr_of(pc[11:0]);
    chk({tag, "_valid"}, dec_valid, 1'b1);
    chk({tag, "_pc"}, dec_pc, pc);
    chk({tag, "_instr"}, dec_instr, ins);
    chk({tag, "_opcode"}, dec_opcode, ins[31:27]);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_en = 1'b0; dec_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [1:0]  live_hist;
    logic        addr_pend;
    logic [31:0] addr_exp;
    int          n_pop;
    bit          found;

    // Reset values and first-fetch latency
    do_reset();
    chk("rst_imem_addr", imem_addr, 12'h000);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_opcode", dec_opcode, 5'h0);
    chk("rst_fq_count", fq_count, 3'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
    @(negedge clock);
    chk("lat_c1_valid", dec_valid, 1'b0);
    chk("lat_c1_addr", imem_addr, 12'h001);
    @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      chk_head("stream", 32'(k));
      chk("stream_count", fq_count, 3'd1);
      @(negedge clock);
    end

    // Back-pressure: queue fills and issue stops
    do_reset();
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b0;
    repeat (10) @(negedge clock);
    chk("full_count", fq_count, 3'd4);
    chk("full_addr", imem_addr, 12'h004);
    chk("full_head", dec_pc, 32'h0);
    dec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head("drain", 32'(k));
      @(negedge clock);
    end

    // Redirect with 3 queued + 1 in flight, dec_ready high on the redirect cycle
    do_reset();
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dec_valid && dec_pc == 32'd5) found = 1'b1;
      else @(negedge clock);
    end
    chk("wait_pc5", found, 1'b1);
    @(negedge clock);
    dec_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fq_count == 3'd3) found = 1'b1;
      else @(negedge clock);
    end
    chk("wait_cnt3", found, 1'b1);
    chk("pre_redir_head", dec_pc, 32'd6);
    redirect = 1'b1; redirect_pc = 32'h40; dec_ready = 1'b1;
    @(negedge clock);
    redirect = 1'b0;
    chk("flush_count", fq_count, 3'd0);
    chk("flush_valid", dec_valid, 1'b0);
    chk("flush_addr", imem_addr, 12'h040);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched6", perf_fetched, 32'd6);
    chk("perf_flushed4", perf_flushed, 32'd4);
`endif
    @(negedge clock);
    chk("flush_c2_valid", dec_valid, 1'b0);
    @(negedge clock);
    chk_head("redir_head", 32'h40);
    @(negedge clock);
    chk_head("redir_next", 32'h41);

    // Mid-run reset, with a redirect that reset must override
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h123;
    repeat (2) @(negedge clock);
    redirect = 1'b0;
    chk("rst2_addr", imem_addr, 12'h000);
    chk("rst2_valid", dec_valid, 1'b0);
    chk("rst2_count", fq_count, 3'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_perf_fetched", perf_fetched, 32'h0);
    chk("rst2_perf_flushed", perf_flushed, 32'h0);
`endif

    // PC wrap at 2^32-1
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clock);
    redirect = 1'b0;
    chk("wrap_addr_fff", imem_addr, 12'hFFF);
    @(negedge clock);
    chk("wrap_addr_000", imem_addr, 12'h000);
    @(negedge clock);
    chk_head("wrap_head_max", 32'hFFFF_FFFF);
    @(negedge clock);
    chk_head("wrap_head_zero", 32'h0);

    // Randomized run against the stream model
    do_reset();
    reset = 1'b0;
    exp_pc = 32'h0; live_hist = 2'b00; addr_pend = 1'b0; addr_exp = '0; n_pop = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_bound", fq_count <= 3'd4, 1'b1);
      chk("rnd_valid_vs_count", dec_valid, fq_count != 3'd0);
      if (addr_pend) chk("rnd_redir_addr", imem_addr, addr_exp[11:0]);
      if (live_hist == 2'b11) chk("rnd_liveness", dec_valid, 1'b1);
      fetch_en  = ($urandom_range(0, 9) < 8);
      dec_ready = ($urandom_range(0, 9) < 7);
      redirect  = ($urandom_range(0, 29) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      redirect_pc = tgt;
      addr_pend = redirect;
      addr_exp  = tgt;
      if (redirect) begin
        exp_pc = tgt;
      end else if (dec_valid && dec_ready) begin
        chk_head("rnd_pop", exp_pc);
        exp_pc = exp_pc + 32'd1;
        n_pop++;
      end
      live_hist = {live_hist[0], fetch_en & ~redirect};
      @(negedge clock);
    end
    redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetched", perf_fetched, 32'(n_pop));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
